// File: rtl/cnet_arb_pkg.sv
// Shared types and constants for the CNET request arbiter.
package cnet_arb_pkg;

    localparam int CPCI_CNET_ADDR_WIDTH = 24;
    localparam int CPCI_CNET_DATA_WIDTH = 32;

    localparam int              FIFO_DEPTH    = 2;
    localparam int              CNT_W         = 2;
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic                            we;
        logic [CPCI_CNET_ADDR_WIDTH-1:0] addr;
        logic [CPCI_CNET_DATA_WIDTH-1:0] data;
    } arb_entry_t;

    typedef enum logic {IDLE, RD_WAIT} rd_state_e;

    typedef enum logic {GNT_REG, GNT_DMA} grant_e;

endpackage

// File: rtl/cnet_arb_fifo.sv
// Two-entry request FIFO with synchronous flush; exposes current and next count.
module cnet_arb_fifo
    import cnet_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    logic [W-1:0]     mem0_q, mem0_d, mem1_q, mem1_d;
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != FIFO_FULL_CNT);
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                if (wr_ptr_q) mem1_d = push_data;
                else          mem0_d = push_data;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head       = rd_ptr_q ? mem1_q : mem0_q;
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/cnet_req_arbiter.sv
// Merges register and DMA requests into one CNET issue port, one read outstanding at a time.
// Build option: define CNET_ARB_DMA_PRIO_EN for strict DMA priority instead of round-robin.
module cnet_req_arbiter
    import cnet_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = CPCI_CNET_ADDR_WIDTH,
    parameter int DATA_WIDTH = CPCI_CNET_DATA_WIDTH
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  reg_req,
    input  logic                  reg_we,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output logic                  reg_busy,
    output logic                  reg_drop,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_data,
    output logic                  dma_busy,
    output logic                  dma_drop,
    output logic                  iface_req,
    output logic                  iface_we,
    output logic [ADDR_WIDTH-1:0] iface_addr,
    output logic [DATA_WIDTH-1:0] iface_data,
    input  logic                  iface_full,
    input  logic                  iface_almost_full,
    input  logic                  iface_rd_rdy,
    input  logic                  iface_rd_timeout,
    input  logic                  cnet_reprog,
    output logic                  rd_pending
);

    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    logic [EW-1:0]    reg_head, dma_head, issue_entry;
    logic [CNT_W-1:0] reg_cnt, reg_cnt_nxt, dma_cnt, dma_cnt_nxt;
    logic             reg_push, dma_push, reg_pop, dma_pop;
    logic             issue_ok, rd_free, reg_elig, dma_elig, gnt_valid;
    grant_e           gnt;

    rd_state_e             rd_state_q, rd_state_d;
    grant_e                last_q, last_d;
    logic                  reg_busy_q, reg_busy_d, dma_busy_q, dma_busy_d;
    logic                  reg_drop_q, reg_drop_d, dma_drop_q, dma_drop_d;
    logic                  iface_req_q, iface_req_d, iface_we_q, iface_we_d;
    logic [ADDR_WIDTH-1:0] iface_addr_q, iface_addr_d;
    logic [DATA_WIDTH-1:0] iface_data_q, iface_data_d;

    assign reg_push = reg_req && !reg_busy_q && !cnet_reprog;
    assign dma_push = dma_req && !dma_busy_q && !cnet_reprog;

    cnet_arb_fifo #(.W(EW)) u_reg_fifo (
        .clk        (pclk),
        .reset      (reset),
        .flush      (cnet_reprog),
        .push       (reg_push),
        .push_data  ({reg_we, reg_addr, reg_data}),
        .pop        (reg_pop),
        .head       (reg_head),
        .count      (reg_cnt),
        .count_next (reg_cnt_nxt)
    );

    cnet_arb_fifo #(.W(EW)) u_dma_fifo (
        .clk        (pclk),
        .reset      (reset),
        .flush      (cnet_reprog),
        .push       (dma_push),
        .push_data  ({1'b1, dma_addr, dma_data}),
        .pop        (dma_pop),
        .head       (dma_head),
        .count      (dma_cnt),
        .count_next (dma_cnt_nxt)
    );

    // An issue in flight plus almost-full would risk overrunning the downstream FIFO.
    assign issue_ok = !cnet_reprog && !iface_full && !(iface_almost_full && iface_req_q);
    assign rd_free  = (rd_state_q == IDLE) || iface_rd_rdy || iface_rd_timeout;
    assign reg_elig = issue_ok && (reg_cnt != '0) && (reg_head[EW-1] || rd_free);
    assign dma_elig = issue_ok && (dma_cnt != '0);

    always_comb begin
        gnt_valid = reg_elig || dma_elig;
`ifdef CNET_ARB_DMA_PRIO_EN
        gnt = dma_elig ? GNT_DMA : GNT_REG;
`else
        if (reg_elig && dma_elig) gnt = (last_q == GNT_DMA) ? GNT_REG : GNT_DMA;
        else                      gnt = dma_elig ? GNT_DMA : GNT_REG;
`endif
        issue_entry = (gnt == GNT_DMA) ? dma_head : reg_head;
        reg_pop     = gnt_valid && (gnt == GNT_REG);
        dma_pop     = gnt_valid && (gnt == GNT_DMA);
        last_d      = gnt_valid ? gnt : last_q;

        iface_req_d  = gnt_valid;
        iface_we_d   = gnt_valid && issue_entry[EW-1];
        iface_addr_d = gnt_valid ? issue_entry[EW-2 -: ADDR_WIDTH] : '0;
        iface_data_d = (gnt_valid && issue_entry[EW-1]) ? issue_entry[DATA_WIDTH-1:0] : '0;

        rd_state_d = rd_state_q;
        if (cnet_reprog)                          rd_state_d = IDLE;
        else if (gnt_valid && !issue_entry[EW-1]) rd_state_d = RD_WAIT;
        else if (iface_rd_rdy || iface_rd_timeout) rd_state_d = IDLE;

        reg_busy_d = cnet_reprog || (reg_cnt_nxt == FIFO_FULL_CNT);
        dma_busy_d = cnet_reprog || (dma_cnt_nxt == FIFO_FULL_CNT);
        reg_drop_d = reg_req && (reg_busy_q || cnet_reprog);
        dma_drop_d = dma_req && (dma_busy_q || cnet_reprog);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            rd_state_q   <= IDLE;
            last_q       <= GNT_DMA;
            reg_busy_q   <= 1'b0;
            dma_busy_q   <= 1'b0;
            reg_drop_q   <= 1'b0;
            dma_drop_q   <= 1'b0;
            iface_req_q  <= 1'b0;
            iface_we_q   <= 1'b0;
            iface_addr_q <= '0;
            iface_data_q <= '0;
        end else begin
            rd_state_q   <= rd_state_d;
            last_q       <= last_d;
            reg_busy_q   <= reg_busy_d;
            dma_busy_q   <= dma_busy_d;
            reg_drop_q   <= reg_drop_d;
            dma_drop_q   <= dma_drop_d;
            iface_req_q  <= iface_req_d;
            iface_we_q   <= iface_we_d;
            iface_addr_q <= iface_addr_d;
            iface_data_q <= iface_data_d;
        end
    end

    assign reg_busy   = reg_busy_q;
    assign dma_busy   = dma_busy_q;
    assign reg_drop   = reg_drop_q;
    assign dma_drop   = dma_drop_q;
    assign iface_req  = iface_req_q;
    assign iface_we   = iface_we_q;
    assign iface_addr = iface_addr_q;
    assign iface_data = iface_data_q;
    assign rd_pending = (rd_state_q == RD_WAIT);

endmodule

// File: tb/tb_cnet_req_arbiter.sv
// Bench for cnet_req_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_cnet_req_arbiter;
  import cnet_arb_pkg::*;

  localparam int AW = CPCI_CNET_ADDR_WIDTH;
  localparam int DW = CPCI_CNET_DATA_WIDTH;
  localparam int EW = 1 + AW + DW;

  logic pclk, reset;
  logic reg_req, reg_we, dma_req;
  logic [AW-1:0] reg_addr, dma_addr, iface_addr;
  logic [DW-1:0] reg_data, dma_data, iface_data;
  logic reg_busy, reg_drop, dma_busy, dma_drop;
  logic iface_req, iface_we, iface_full, iface_almost_full;
  logic iface_rd_rdy, iface_rd_timeout, cnet_reprog, rd_pending;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  cnet_req_arbiter dut (
    .pclk(pclk), .reset(reset),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_busy(reg_busy), .reg_drop(reg_drop),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data),
    .dma_busy(dma_busy), .dma_drop(dma_drop),
    .iface_req(iface_req), .iface_we(iface_we), .iface_addr(iface_addr), .iface_data(iface_data),
    .iface_full(iface_full), .iface_almost_full(iface_almost_full),
    .iface_rd_rdy(iface_rd_rdy), .iface_rd_timeout(iface_rd_timeout),
    .cnet_reprog(cnet_reprog), .rd_pending(rd_pending)
  );

  // clock / reset
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: one queue per requester, plus read-outstanding flag
  logic [EW-1:0] exp_reg_q[$];
  logic [EW-1:0] exp_dma_q[$];
  logic m_rdwait, m_last_dma, m_req, m_we, m_rbusy, m_dbusy, m_rdrop, m_ddrop;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always @(posedge pclk) begin
    logic ok, rd_free, r_el, d_el, pick_dma, any;
    logic [EW-1:0] ent;
    if (reset) begin
      exp_reg_q.delete();
      exp_dma_q.delete();
      m_rdwait = 0; m_last_dma = 1;
      m_req = 0; m_we = 0; m_addr = '0; m_data = '0;
      m_rbusy = 0; m_dbusy = 0; m_rdrop = 0; m_ddrop = 0;
    end else begin
      m_rdrop = reg_req && (m_rbusy || cnet_reprog);
      m_ddrop = dma_req && (m_dbusy || cnet_reprog);
      if (cnet_reprog) begin
        exp_reg_q.delete();
        exp_dma_q.delete();
        m_rdwait = 0;
        m_req = 0; m_we = 0; m_addr = '0; m_data = '0;
      end else begin
        ok = !iface_full && !(iface_almost_full && m_req);
        rd_free = !m_rdwait || iface_rd_rdy || iface_rd_timeout;
        r_el = ok && exp_reg_q.size() > 0 && (exp_reg_q[0][EW-1] || rd_free);
        d_el = ok && exp_dma_q.size() > 0;
        any = r_el || d_el;
`ifdef CNET_ARB_DMA_PRIO_EN
        pick_dma = d_el;
`else
        pick_dma = (r_el && d_el) ? !m_last_dma : d_el;
`endif
        ent = '0;
        if (any) begin
          ent = pick_dma ? exp_dma_q.pop_front() : exp_reg_q.pop_front();
          m_last_dma = pick_dma;
          m_req = 1;
          m_we = ent[EW-1];
          m_addr = ent[EW-2 -: AW];
          m_data = ent[EW-1] ? ent[DW-1:0] : '0;
        end else begin
          m_req = 0; m_we = 0; m_addr = '0; m_data = '0;
        end
        if (any && !ent[EW-1]) m_rdwait = 1;
        else if (iface_rd_rdy || iface_rd_timeout) m_rdwait = 0;
        if (reg_req && !m_rbusy) exp_reg_q.push_back({reg_we, reg_addr, reg_data});
        if (dma_req && !m_dbusy) exp_dma_q.push_back({1'b1, dma_addr, dma_data});
      end
      m_rbusy = cnet_reprog || exp_reg_q.size() == 2;
      m_dbusy = cnet_reprog || exp_dma_q.size() == 2;
    end
  end

  // scoreboard: compare every cycle, log issues for directed checks
  typedef struct {
    int cyc;
    logic we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } issue_t;
  issue_t log_q[$];

  always @(negedge pclk) begin
    lit("iface_bundle", {iface_req, iface_we, iface_addr, iface_data}, {m_req, m_we, m_addr, m_data});
    lit("status_bundle", {rd_pending, reg_busy, dma_busy, reg_drop, dma_drop},
        {m_rdwait, m_rbusy, m_dbusy, m_rdrop, m_ddrop});
    if (iface_req) log_q.push_back('{cyc: cyc, we: iface_we, addr: iface_addr, data: iface_data});
  end

  function automatic issue_t get_issue(int i);
    issue_t e;
    e = '{cyc: -1, we: 1'b0, addr: '0, data: '0};
    if (i < log_q.size()) e = log_q[i];
    return e;
  endfunction

  // driver tasks
  task automatic cycle();
    @(posedge pclk);
    #1;
    reg_req = 0; dma_req = 0; iface_rd_rdy = 0; iface_rd_timeout = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    log_q.delete();
  endtask

  task automatic reg_strobe(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_req = 1; reg_we = we; reg_addr = a; reg_data = d;
  endtask

  task automatic dma_strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = 1; dma_addr = a; dma_data = d;
  endtask

  initial begin
    int c0, t;
    int n;
    issue_t e;
    logic [AW-1:0] exp_addr[4];
    reset = 1;
    reg_req = 0; reg_we = 0; reg_addr = '0; reg_data = '0;
    dma_req = 0; dma_addr = '0; dma_data = '0;
    iface_full = 0; iface_almost_full = 0; iface_rd_rdy = 0; iface_rd_timeout = 0;
    cnet_reprog = 0;

    // reset state and single write latency
    do_reset();
    lit("reset_outputs", {iface_req, iface_we, reg_busy, dma_busy, reg_drop, dma_drop, rd_pending}, 7'b0);
    c0 = cyc;
    reg_strobe(1, 24'h100, 32'hDEADBEEF);
    cycle();
    repeat (4) cycle();
    e = get_issue(0);
    lit("wr_count", log_q.size(), 1);
    lit("wr_latency", e.cyc, c0 + 2);
    lit("wr_fields", {e.we, e.addr, e.data}, {1'b1, 24'h100, 32'hDEADBEEF});
    lit("wr_rd_pending", rd_pending, 0);

    // read, write, blocked read released by rd_rdy
    do_reset();
    c0 = cyc;
    reg_strobe(0, 24'h200, 32'h5555);
    cycle();
    reg_strobe(1, 24'h204, 32'h11);
    cycle();
    reg_strobe(0, 24'h208, 32'h7777);
    cycle();
    repeat (4) cycle();
    e = get_issue(0);
    lit("rd0_fields", {e.cyc, 7'b0, e.we, e.addr, e.data}, {c0 + 2, 7'b0, 1'b0, 24'h200, 32'h0});
    e = get_issue(1);
    lit("wr_behind_rd", {e.cyc, 7'b0, e.we, e.addr}, {c0 + 3, 7'b0, 1'b1, 24'h204});
    lit("rd1_stalled", log_q.size(), 2);
    lit("rd_pending_hi", rd_pending, 1);
    t = cyc;
    iface_rd_rdy = 1;
    cycle();
    repeat (3) cycle();
    e = get_issue(2);
    lit("rd1_after_rdy", {e.cyc, 7'b0, e.we, e.addr}, {t + 1, 7'b0, 1'b0, 24'h208});
    lit("rd_pending_again", rd_pending, 1);
    iface_rd_rdy = 1;
    cycle();
    cycle();
    lit("rd_pending_clear", rd_pending, 0);

    // contention with downstream full: drops, busy, order after release
    do_reset();
    iface_full = 1;
    for (int i = 0; i < 3; i++) begin
      reg_strobe(1, 24'h300 + 24'(i * 4), 32'(i));
      dma_strobe(24'h400 + 24'(i * 4), 32'h100 + 32'(i));
      cycle();
    end
    lit("drop_pulse", {reg_drop, dma_drop}, 2'b11);
    cycle();
    lit("drop_one_cycle", {reg_drop, dma_drop}, 2'b00);
    repeat (6) cycle();
    lit("full_busy", {reg_busy, dma_busy}, 2'b11);
    lit("full_no_issue", log_q.size(), 0);
    t = cyc;
    iface_full = 0;
    repeat (6) cycle();
`ifdef CNET_ARB_DMA_PRIO_EN
    exp_addr[0] = 24'h400; exp_addr[1] = 24'h404; exp_addr[2] = 24'h300; exp_addr[3] = 24'h304;
`else
    exp_addr[0] = 24'h300; exp_addr[1] = 24'h400; exp_addr[2] = 24'h304; exp_addr[3] = 24'h404;
`endif
    lit("order_count", log_q.size(), 4);
    lit("first_after_full", get_issue(0).cyc, t + 1);
    for (int i = 0; i < 4; i++) lit($sformatf("order_%0d", i), get_issue(i).addr, exp_addr[i]);

    // read timeout releases the next read
    do_reset();
    reg_strobe(0, 24'h500, 32'h0);
    cycle();
    reg_strobe(0, 24'h504, 32'h0);
    cycle();
    repeat (4) cycle();
    lit("to_stalled", log_q.size(), 1);
    t = cyc;
    iface_rd_timeout = 1;
    cycle();
    repeat (3) cycle();
    e = get_issue(1);
    lit("to_next_read", {e.cyc, 7'b0, e.we, e.addr}, {t + 1, 7'b0, 1'b0, 24'h504});
    iface_rd_timeout = 1;
    cycle();

    // reprogram flush with queued entries and pending read
    do_reset();
    reg_strobe(0, 24'h600, 32'h0);
    cycle();
    repeat (3) cycle();
    iface_full = 1;
    reg_strobe(1, 24'h604, 32'hA);
    cycle();
    reg_strobe(1, 24'h608, 32'hB);
    cycle();
    cycle();
    lit("pre_reprog", {rd_pending, reg_busy}, 2'b11);
    cnet_reprog = 1;
    iface_full = 0;
    repeat (3) cycle();
    lit("reprog_held", {rd_pending, reg_busy, dma_busy}, 3'b011);
    n = log_q.size();
    cnet_reprog = 0;
    repeat (5) cycle();
    lit("reprog_no_issue", log_q.size(), n);
    lit("reprog_idle", {rd_pending, reg_busy, dma_busy}, 3'b000);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reg_req = ($urandom_range(0, 99) < 45);
      reg_we = $urandom_range(0, 1);
      reg_addr = AW'($urandom);
      reg_data = $urandom;
      dma_req = ($urandom_range(0, 99) < 35);
      dma_addr = AW'($urandom);
      dma_data = $urandom;
      iface_full = ($urandom_range(0, 99) < 10);
      iface_almost_full = ($urandom_range(0, 99) < 25);
      iface_rd_rdy = ($urandom_range(0, 99) < 12);
      iface_rd_timeout = ($urandom_range(0, 99) < 3);
      cnet_reprog = ($urandom_range(0, 999) < 8);
      reset = ($urandom_range(0, 999) < 3);
      @(posedge pclk);
      #1;
    end
    reset = 0; cnet_reprog = 0; iface_full = 0;
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnet_req_arbiter.md
# cnet_req_arbiter

Request arbiter and read sequencer in front of the CPCI→CNET register interface, in the `pclk` domain. Merges PCI register requests (reads and writes) and DMA writes into the single request port of `cnet_reg_iface`. Enforces at most one outstanding CNET read, honours FIFO backpressure, and flushes cleanly when the CNET is reprogrammed.

## Interface
- `ADDR_WIDTH`, default `CPCI_CNET_ADDR_WIDTH`: request address width.
- `DATA_WIDTH`, default `CPCI_CNET_DATA_WIDTH`: request data width.

One clock (`pclk`); reset `reset` is synchronous, active-high.

- `pclk`  in  1  system clock
- `reset`  in  1  synchronous active-high reset
- `reg_req`  in  1  register request strobe, one cycle per request
- `reg_we`  in  1  1 = write, 0 = read
- `reg_addr`  in  ADDR_WIDTH  register address
- `reg_data`  in  DATA_WIDTH  register write data
- `reg_busy`  out  1  register queue full; requests ignored
- `reg_drop`  out  1  one-cycle pulse: `reg_req` arrived while busy
- `dma_req`  in  1  DMA write strobe
- `dma_addr`  in  ADDR_WIDTH  DMA address
- `dma_data`  in  DATA_WIDTH  DMA data
- `dma_busy`  out  1  DMA queue full
- `dma_drop`  out  1  one-cycle pulse: `dma_req` arrived while busy
- `iface_req`  out  1  one-cycle issue strobe to `cnet_reg_iface`
- `iface_we`  out  1  issued direction
- `iface_addr`  out  ADDR_WIDTH  issued address
- `iface_data`  out  DATA_WIDTH  issued data; 0 for reads
- `iface_full`  in  1  downstream `p2n_full`
- `iface_almost_full`  in  1  downstream `p2n_almost_full`
- `iface_rd_rdy`  in  1  read reply returned (`n2p_rd_rdy`)
- `iface_rd_timeout`  in  1  read timed out (`cnet_rd_timeout`)
- `cnet_reprog`  in  1  CNET reprogramming in progress
- `rd_pending`  out  1  a read is outstanding

## Operation
- Each requester feeds a private 2-entry FIFO of entries {we, addr, data}.
  - A strobe while the FIFO is not full is enqueued.
  - A strobe while full is discarded and pulses `*_drop`.
  - `*_busy` = FIFO count == 2.
  - DMA entries always have we = 1.
- Issue eligibility: at most one issue per cycle. All of the following must hold:
  - `cnet_reprog` low.
  - `iface_full` low.
  - Not (`iface_almost_full` and `iface_req` high this cycle).
- Head blocking:
  - A read head is eligible only if the read FSM is IDLE, or `iface_rd_rdy` / `iface_rd_timeout` is high this cycle.
  - A blocked head stalls only its own queue; order within a queue is preserved.
- Arbitration: round-robin between eligible heads. The last-granted pointer toggles only on an actual grant. Reset value is DMA-last, so the register queue wins the first tie.
- Read FSM:
  - IDLE → RD_WAIT when a read issues.
  - RD_WAIT → IDLE on `iface_rd_rdy` or `iface_rd_timeout`.
  - Release and a new read issue in the same cycle leave the FSM in RD_WAIT.
  - `rd_pending` = (state == RD_WAIT).
- `cnet_reprog` high:
  - Both FIFOs cleared, FSM → IDLE, no issue.
  - `*_busy` held high, so incoming strobes are dropped with `*_drop` pulses.
  - Normal operation resumes the cycle after deassertion.
- Reset values: all outputs 0, FIFOs empty, FSM IDLE. Reset mid-read abandons the read; a late `iface_rd_rdy` in IDLE is ignored.

## Timing
- Strobe in cycle 0 → FIFO write at edge 1 → `iface_req` registered at edge 2 and high during cycle 2. Minimum latency is 2 cycles with an idle FIFO and no contention.
- All `iface_*` outputs are registered. `iface_req` lasts one cycle; `iface_we`/`iface_addr`/`iface_data` are valid only while `iface_req` is high, and 0 otherwise.
- `*_busy` is registered and reflects count after the current edge. Back-to-back strobes are accepted until count == 2.
- Sustained throughput is one issue per cycle while downstream is not almost full. Under almost-full, issues are spaced at least 2 cycles apart.

## Configuration
- `CNET_ARB_DMA_PRIO_EN`
  - Defined: strict priority to the eligible DMA head. The register queue issues only when the DMA queue is empty or its head is ineligible.
  - Undefined: round-robin as above.
  - All other behaviour is identical in both builds.

## Structure
- Package `cnet_arb_pkg`:
  - entry struct {we, addr, data}
  - read-FSM state enum {IDLE, RD_WAIT}
  - grant enum {GNT_REG, GNT_DMA}
  - FIFO depth constant (2)
- Sub-module `cnet_arb_fifo`: 2-entry FIFO with synchronous flush and count output, instantiated twice. Arbitration and FSM live in the top.

## Test plan
- Single reg write 0x100/0xDEADBEEF → `iface_req` in cycle 2 with we = 1, addr 0x100, data 0xDEADBEEF; `rd_pending` stays 0.
- Reg read 0x200, then reg write 0x204 next cycle → read issues and `rd_pending` = 1.
  - Write 0x204 still issues (it is not behind a read head).
  - A second read 0x208 stalls until `iface_rd_rdy` pulses, then issues that same cycle.
- Reg and DMA strobes in the same cycle, 3 each → issue order REG, DMA, REG, DMA with `*_drop` pulsing on the third strobe of each.
  - With `CNET_ARB_DMA_PRIO_EN`: DMA, DMA, REG, REG.
- `iface_full` held high for 10 cycles with both FIFOs full → no `iface_req`, both `*_busy` = 1. First issue occurs the cycle after `iface_full` drops.
- Read outstanding, then `iface_rd_timeout` pulse → FSM returns to IDLE and the next queued read issues.
- `cnet_reprog` asserted with 2 queued entries and a pending read → FIFOs empty, `rd_pending` = 0, and no issue after deassertion.
